// File: rtl/bus_gate_arbiter_if.sv
// Bus gate arbiter port bundle: source requests/data
// and the registered valid/ready bus toward the sink.
interface bus_gate_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int OW = ($clog2(N) > 1) ? $clog2(N) : 1;

    logic [N-1:0]       Req;
    logic [N*WIDTH-1:0] Data_in;
    logic [N-1:0]       Last;
    logic [N-1:0]       Grant;
    logic [N-1:0]       Ack;
    logic [OW-1:0]      Owner;
    logic [WIDTH-1:0]   Bus_out;
    logic               Bus_valid;
    logic               Bus_ready;
    logic               Timeout_err;

    modport slave (
        input  Req, Data_in, Last, Bus_ready,
        output Grant, Ack, Owner, Bus_out,
        output Bus_valid, Timeout_err
    );

    modport master (
        output Req, Data_in, Last, Bus_ready,
        input  Grant, Ack, Owner, Bus_out,
        input  Bus_valid, Timeout_err
    );
endinterface

// File: rtl/bus_gate_arbiter.sv
// N-source round-robin bus gate with burst ownership, hold-limit
// timeout and registered output. BUS_GATE_FIXED_PRIO_EN: fixed priority.
module bus_gate_arbiter #(
    parameter int WIDTH    = 16,
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic              Clk,
    input logic              Reset_n,
    bus_gate_arbiter_if.slave bus
);
    localparam int OW = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    win, nxt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] bus_q, slice;
    logic             valid_q;
    logic             terr_q, terr_d;
    logic             ld, hit_max, own_last;

    assign slice    = bus.Data_in[int'(owner_q)*WIDTH +: WIDTH];
    assign own_last = bus.Last[owner_q];
    assign hit_max  = (cnt_q == CW'(MAX_HOLD - 1));
    assign ld       = (state_q == OWN) & bus.Req[owner_q]
                    & (~valid_q | bus.Bus_ready);

    assign bus.Ack         = ld ? grant_q : '0;
    assign bus.Grant       = grant_q;
    assign bus.Owner       = owner_q;
    assign bus.Bus_out     = bus_q;
    assign bus.Bus_valid   = valid_q;
    assign bus.Timeout_err = terr_q;

    // Winner: first requester searching upward from ptr with wrap
    always_comb begin
        int idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && bus.Req[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
    end

`ifdef BUS_GATE_FIXED_PRIO_EN
    assign nxt = '0;
`else
    assign nxt = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
`endif

    // Ownership FSM: next state, grant, pointer and beat count
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.Req) begin
                    state_d = OWN;
                    grant_d = N'(1) << win;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (ld)
                    cnt_d = cnt_q + 1'b1;
                terr_d = ld & ~own_last & hit_max;
                if ((ld && (own_last || hit_max)) ||
                    !bus.Req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    owner_d = '0;
                    ptr_d   = nxt;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // FSM state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Output stage: load on ld, drain to zero when sink takes it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else if (ld) begin
            bus_q   <= slice;
            valid_q <= 1'b1;
        end else if (bus.Bus_ready) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/bus_gate_arbiter.md
Name: bus_gate_arbiter

Overview:
Parametrised N-source bus gate with round-robin arbitration, burst ownership and a registered, valid/ready-handshaked output.
- Replaces the combinational one-hot bus gate with a sequential arbiter plus a one-stage output register.
- Sits between datapath sources (MDR/ALU/PC/MAR and others) and the shared internal bus.
- Bounds ownership with a hold-limit timeout.

Parameters:
WIDTH, 16, data width of each source and of the bus
N, 4, number of sources (N >= 2)
MAX_HOLD, 8, maximum beats per ownership before forced release (>= 1)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Req  in  N  per-source request; Req[i] high = source i has a beat on its Data_in slice
Data_in  in  N*WIDTH  source data; slice i = Data_in[i*WIDTH +: WIDTH]
Last  in  N  per-source last-beat marker, qualified by Ack[i]
Grant  out  N  one-hot ownership, level; all zero when idle
Ack  out  N  per-source beat-accepted strobe, combinational
Owner  out  max(1,$clog2(N))  index of current owner; 0 when idle
Bus_out  out  WIDTH  registered bus data; 0 whenever Bus_valid = 0
Bus_valid  out  1  output register holds a beat
Bus_ready  in  1  sink accepts Bus_out this cycle
Timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, Reset_n = 0): state IDLE, Grant = 0, Owner = 0, Bus_out = 0, Bus_valid = 0, Timeout_err = 0, RR pointer = 0, beat_cnt = 0. In-flight beats are discarded. No Ack is asserted while in reset.
- States: IDLE, OWN.
- IDLE:
  - If any Req bit is set, the winner is the first set bit searching from ptr upward, with modulo-N wrap.
  - Next cycle: state OWN, Grant = onehot(winner), Owner = winner, beat_cnt = 0.
  - Arbitration latency is 1 cycle. No Ack is issued in IDLE.
- OWN, load condition: ld = Req[Owner] & (~Bus_valid | Bus_ready).
  - Ack[Owner] = ld; all other Ack bits are 0.
  - On ld: Bus_out <= Data_in slice of Owner, Bus_valid <= 1, beat_cnt <= beat_cnt + 1.
- Output register, independent of state:
  - If no load occurs and Bus_ready = 1, then Bus_valid <= 0 and Bus_out <= 0.
  - If Bus_valid = 1 and Bus_ready = 0, Bus_out and Bus_valid hold.
  - Simultaneous drain and load in the same cycle gives full throughput of 1 beat/cycle.
- Release, evaluated in OWN, priority order:
  (a) ld with Last[Owner] = 1: normal release.
  (b) ld with beat_cnt + 1 == MAX_HOLD and Last[Owner] = 0: forced release; Timeout_err = 1 for the following cycle.
  (c) Req[Owner] = 0: release, no error, no beat.
- On any release:
  - Next cycle: state IDLE, Grant = 0, Owner = 0, ptr <= (Owner + 1) mod N.
  - Minimum gap between owners is 1 IDLE cycle.
  - The output register keeps draining during IDLE.
- A source losing ownership while it still has Req high re-arbitrates like any other source.
- Req bits of non-owners are ignored during OWN.
- Data_in and Last are sampled only on ld.
- Boundaries:
  - MAX_HOLD = 1: every beat releases.
  - A burst exactly MAX_HOLD long ending with Last releases via (a), with no Timeout_err.
  - ptr wraps from N-1 to 0.

Optional Feature:
BUS_GATE_FIXED_PRIO_EN
- Defined: IDLE picks the lowest-index set Req bit; ptr is unused and held at 0.
- Undefined: round-robin as above.
- All other behaviour, including the MAX_HOLD timeout, is identical in both builds.

Test Plan:
1. Single burst: Req[2] = 1 with 3 beats A1, A2, A3, Last on A3, Bus_ready = 1.
   - Required: Grant = 0100 one cycle after Req.
   - Required: Bus_out = A1, A2, A3 on consecutive cycles, then 0.
   - Required: Grant = 0 after the A3 Ack; Timeout_err stays 0.
2. Round-robin: Req = 1111, each source sends 1 beat with Last.
   - Required: grant order 0, 1, 2, 3, 0.
   - Required: one IDLE cycle between consecutive grants.
3. Backpressure: owner streams; Bus_ready = 0 for 3 cycles with Bus_valid = 1.
   - Required: Bus_out holds; Ack = 0 during the stall.
   - Required: when Bus_ready rises, the next beat loads in the same cycle and no beat is lost or duplicated.
4. Timeout: MAX_HOLD = 8; source 1 offers 10 beats with no Last.
   - Required: exactly 8 Acks, then Timeout_err = 1 for one cycle.
   - Required: ptr = 2; source 1 is regranted only after other requesters are served.
5. Reset mid-burst: assert Reset_n = 0 after beat 2 of 5, asynchronously between clock edges.
   - Required: all outputs are 0 immediately.
   - Required: after release, a fresh grant goes to the lowest requesting index from ptr = 0.
6. BUS_GATE_FIXED_PRIO_EN defined, Req = 1010 continuously, 1-beat bursts.
   - Required: source 1 wins every arbitration; source 3 is never granted.
